// File: rtl/col2im.sv
// col2im: folds an im2col column matrix back into an HWC image by scatter-accumulating patch elements.
// Optional feature: define COL2IM_SAT_EN to saturate accumulators to DATA_WIDTH on write-back (default truncates).
module col2im #(
  parameter int IMG_C       = 1,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int FILTER_SIZE = 3,
  parameter int ACC_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] IMG_BASE    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_rd,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic                  mem_wr_en,
  output logic                  done
);
  localparam int K    = FILTER_SIZE;
  localparam int P    = (K - 1) / 2;
  localparam int NPIX = IMG_C * IMG_H * IMG_W;
  localparam int PW   = NPIX > 1 ? $clog2(NPIX) : 1;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t                 state;
  logic [15:0]            c, r, w, fr, fc;
  logic [15:0]            dc, dr, dw, dfr, dfc;
  logic                   dv;
  logic [PW-1:0]          wp;
  logic [ACC_WIDTH-1:0]   acc [NPIX];
  logic                   wrap_fc, wrap_fr, wrap_w, wrap_r, last, hit, clr;
  int                     yy, xx;
  logic [PW-1:0]          tgt;
  logic [ACC_WIDTH-1:0]   ext, first;

  function automatic logic [DATA_WIDTH-1:0] narrow(input logic [ACC_WIDTH-1:0] a);
`ifdef COL2IM_SAT_EN
    narrow = (a > ACC_WIDTH'({DATA_WIDTH{1'b1}})) ? '1 : a[DATA_WIDTH-1:0];
`else
    narrow = a[DATA_WIDTH-1:0];
`endif
  endfunction

  // Patch index wrap detection and scatter target for the element whose data is arriving now
  always_comb begin
    wrap_fc = fc == 16'(K - 1);
    wrap_fr = wrap_fc && fr == 16'(K - 1);
    wrap_w  = wrap_fr && w == 16'(IMG_W - 1);
    wrap_r  = wrap_w && r == 16'(IMG_H - 1);
    last    = wrap_r && c == 16'(IMG_C - 1);
    yy      = int'(dr) + int'(dfr) - P;
    xx      = int'(dw) + int'(dfc) - P;
    hit     = dv && yy >= 0 && yy < IMG_H && xx >= 0 && xx < IMG_W;
    tgt     = PW'((yy * IMG_W + xx) * IMG_C + int'(dc));
    ext     = ACC_WIDTH'(data_rd);
    first   = (hit && tgt == '0) ? acc[0] + ext : acc[0];
    clr     = start && (state == IDLE || state == DONE);
  end

  // Accumulator bank: cleared on an accepted start, otherwise adds each in-image element
  always_ff @(posedge clk)
    if (clr)
      for (int i = 0; i < NPIX; i++) acc[i] <= '0;
    else if (hit)
      acc[tgt] <= acc[tgt] + ext;

  // Control FSM: sequential column read, one drain cycle, then linear image write-back
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      addr_rd   <= IM2COL_BASE;
      addr_wr   <= IMG_BASE;
      data_wr   <= '0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      {c, r, w, fr, fc}      <= '0;
      {dc, dr, dw, dfr, dfc} <= '0;
      dv        <= 1'b0;
      wp        <= '0;
    end else begin
      dv <= state == READ;
      {dc, dr, dw, dfr, dfc} <= {c, r, w, fr, fc};
      case (state)
        IDLE, DONE: if (start) begin
          done    <= 1'b0;
          addr_rd <= IM2COL_BASE;
          state   <= READ;
        end
        READ: begin
          fc      <= wrap_fc ? '0 : fc + 1'b1;
          fr      <= wrap_fr ? '0 : wrap_fc ? fr + 1'b1 : fr;
          w       <= wrap_w ? '0 : wrap_fr ? w + 1'b1 : w;
          r       <= wrap_r ? '0 : wrap_w ? r + 1'b1 : r;
          c       <= last ? '0 : wrap_r ? c + 1'b1 : c;
          addr_rd <= last ? addr_rd : addr_rd + 1'b1;
          state   <= last ? DRAIN : READ;
        end
        DRAIN: begin
          addr_wr   <= IMG_BASE;
          data_wr   <= narrow(first);
          mem_wr_en <= 1'b1;
          wp        <= '0;
          state     <= WRITE;
        end
        WRITE: if (wp == PW'(NPIX - 1)) begin
          mem_wr_en <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end else begin
          wp      <= wp + 1'b1;
          addr_wr <= addr_wr + 1'b1;
          data_wr <= narrow(acc[wp + 1'b1]);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_col2im.sv
// tb_col2im: randomized and directed checks of col2im (C=1 and C=2, 4x4 image, K=3) against a behavioural fold model.
module tb_col2im;
`ifdef COL2IM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start     [2];
  logic [7:0]  data_rd   [2];
  logic [31:0] addr_rd   [2];
  logic [31:0] addr_wr   [2];
  logic [7:0]  data_wr   [2];
  logic        mem_wr_en [2];
  logic        done      [2];
  logic [7:0]  col  [2][288];
  logic [7:0]  wimg [2][32];
  logic [7:0]  ref_img [32];
  int          wr_cnt [2];
  int          bad    [2];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    col2im #(.IMG_C(g + 1), .IMG_W(4), .IMG_H(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .data_rd(data_rd[g]),
      .addr_rd(addr_rd[g]), .data_wr(data_wr[g]), .addr_wr(addr_wr[g]),
      .mem_wr_en(mem_wr_en[g]), .done(done[g]));
  end

  // Column memory with one-cycle read latency
  always @(posedge clk)
    for (int g = 0; g < 2; g++) data_rd[g] <= col[g][9'(addr_rd[g] - 32'h2000)];

  // Image memory write capture
  always @(negedge clk)
    for (int g = 0; g < 2; g++)
      if (mem_wr_en[g]) begin
        wr_cnt[g]++;
        if (addr_wr[g] < 32'((g + 1) * 16)) wimg[g][5'(addr_wr[g])] = data_wr[g];
        else bad[g]++;
      end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: constant v, 1: channel c gets c+1, 2: random, 3: only element 45 = v
  task automatic fill(input int u, input int mode, input logic [7:0] v);
    for (int i = 0; i < 288; i++)
      col[u][i] = mode == 0 ? v : mode == 1 ? 8'(i / 144 + 1) :
                  mode == 2 ? 8'($urandom_range(0, 255)) : (i == 45 ? v : 8'h00);
  endtask

  // Fold the column matrix directly from the geometric definition
  task automatic build_ref(input int u);
    int cc = u + 1;
    int acc [32];
    for (int p = 0; p < 32; p++) acc[p] = 0;
    for (int i = 0; i < cc * 144; i++) begin
      int fc = i % 3;
      int fr = (i / 3) % 3;
      int x  = (i / 9) % 4 + fc - 1;
      int y  = (i / 36) % 4 + fr - 1;
      int ch = i / 144;
      if (y >= 0 && y < 4 && x >= 0 && x < 4) acc[(y * 4 + x) * cc + ch] += int'(col[u][i]);
    end
    for (int p = 0; p < 32; p++) ref_img[p] = SAT ? (acc[p] > 255 ? 8'hFF : 8'(acc[p])) : 8'(acc[p] % 256);
  endtask

  task automatic run(input int u, input bit inject);
    int n = (u + 1) * 144;
    int npix = (u + 1) * 16;
    int cyc = 0;
    bit injected = 1'b0;
    wr_cnt[u] = 0;
    bad[u] = 0;
    for (int p = 0; p < 32; p++) wimg[u][p] = 8'hEE;
    @(negedge clk) start[u] = 1'b1;
    @(posedge clk);
    #1 start[u] = 1'b0;
    check("done_drop", 32'(done[u]), 0);
    while (!done[u] && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
      if (inject) begin
        start[u] = !injected && mem_wr_en[u];
        injected = injected || mem_wr_en[u];
      end
    end
    start[u] = 1'b0;
    check("latency", cyc, n + 1 + npix);
    check("wr_cnt", wr_cnt[u], npix);
    check("bad_addr", bad[u], 0);
    build_ref(u);
    for (int p = 0; p < npix; p++) check($sformatf("u%0d_pix%0d", u, p), wimg[u][p], ref_img[p]);
  endtask

  initial begin
    rst_n = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr_rd", addr_rd[0], 32'h2000);
    check("rst_addr_wr", addr_wr[0], 0);
    check("rst_data_wr", data_wr[0], 0);
    check("rst_wr_en", 32'(mem_wr_en[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    @(negedge clk) rst_n = 1'b1;

    fill(0, 0, 8'h01);
    run(0, 1'b0);
    check("ones_corner", wimg[0][0], 4);
    check("ones_edge", wimg[0][1], 6);
    check("ones_inner", wimg[0][5], 9);
    check("ones_corner15", wimg[0][15], 4);

    fill(0, 0, 8'hFF);
    run(0, 1'b1);
    check("ff_corner", wimg[0][0], SAT ? 32'hFF : 32'hFC);
    check("ff_edge", wimg[0][1], SAT ? 32'hFF : 32'hFA);
    check("ff_inner", wimg[0][5], SAT ? 32'hFF : 32'hF7);

    fill(1, 1, 8'h00);
    run(1, 1'b0);
    check("c2_corner0", wimg[1][0], 4);
    check("c2_corner1", wimg[1][1], 8);
    check("c2_edge1", wimg[1][3], 12);
    check("c2_inner1", wimg[1][11], 18);

    fill(0, 3, 8'h7F);
    run(0, 1'b0);
    check("onehot", wimg[0][0], 32'h7F);

    fill(0, 2, 8'h00);
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_addr_rd", addr_rd[0], 32'h2000);
    check("abort_addr_wr", addr_wr[0], 0);
    check("abort_data_wr", data_wr[0], 0);
    check("abort_wr_en", 32'(mem_wr_en[0]), 0);
    check("abort_done", 32'(done[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill(0, 0, 8'h01);
    run(0, 1'b0);
    check("abort_inner", wimg[0][5], 9);
    check("abort_corner", wimg[0][0], 4);

    for (int k = 0; k < 3; k++) begin
      fill(0, 2, 8'h00);
      run(0, k == 1);
      fill(1, 2, 8'h00);
      run(1, k == 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
